// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter family.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
//
// Contents: state enum, FIFO geometry constants, statistics counter width
// and a saturating-increment helper for the optional statistics counters.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DEPTH = 64;
    localparam int FIFO_CNT_W = 8;
    localparam int ARB_LEN_W  = 4;
    localparam int STAT_W     = 16;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin one-hot picker: first set request searching upward from last+1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
//
// Ports:
//   req    - request vector, one bit per requester
//   last   - index of the most recently served requester
//   gnt_oh - one-hot winner (all zero when no request)
//   idx    - binary index of the winner (0 when no request)
//   any    - at least one request is pending
module fifo_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // Walk from the farthest candidate (last itself) to the nearest (last+1);
    // the last hit overwrites earlier ones, so the nearest set bit wins.
    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        pos    = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IW'((int'(last) + k) % N);
            if (req[pos]) begin
                gnt_oh      = '0;
                gnt_oh[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter and burst sequencer in front of a byte FIFO.
// Latency: request to grant/first write is 1 cycle; then 1 word per cycle.
// Backpressure: bursts admitted only if the whole burst fits; fifo_full stalls.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   req/req_len/req_data - per-requester request level, length-1, data lane
//   gnt, data_ack       - one-hot grant for the whole burst, per-word ack pulse
//   fifo_wr_en/fifo_din - FIFO write port
//   fifo_full/fifo_count - FIFO back-pressure inputs
//   busy                - high while a burst is in progress
// Optional macro FIFO_ARB_STATS_EN adds stat_grants/stat_stalls/stat_blocked.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int LEN_W = ARB_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ*DW-1:0]    req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       data_ack,
    output logic                   fifo_wr_en,
    output logic [DW-1:0]          fifo_din,
    input  logic                   fifo_full,
    input  logic [FIFO_CNT_W-1:0]  fifo_count,
    output logic                   busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0]       stat_stalls,
    output logic [STAT_W-1:0]       stat_blocked
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    w_q;
    logic [IW-1:0]    last_q;
    logic [LEN_W-1:0] rem_q;

    logic [N_REQ-1:0]      pick_oh;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic [LEN_W-1:0]      sel_len;
    logic [FIFO_CNT_W-1:0] need;
    logic                  admit;

    fifo_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // One-hot mux of the winner's length field.
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) sel_len = sel_len | req_len[i*LEN_W +: LEN_W];
        end
    end

    // Occupancy after the whole burst; 8 bits cannot overflow for count<=DEPTH.
    assign need  = fifo_count + FIFO_CNT_W'(sel_len) + FIFO_CNT_W'(1);
    assign admit = pick_any && (need <= FIFO_CNT_W'(DEPTH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A blocked head request is retried rather than
    // skipped, so long bursts are not starved by short ones.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (admit) state_nxt = ST_BURST;
            ST_BURST: if (!fifo_full && rem_q == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gnt        = '0;
        data_ack   = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        busy       = 1'b0;
        if (state == ST_BURST) begin
            busy       = 1'b1;
            gnt[w_q]   = 1'b1;
            fifo_wr_en = !fifo_full;
            fifo_din   = req_data[w_q*DW +: DW];
            if (!fifo_full) data_ack[w_q] = 1'b1;
        end
    end

    // Burst bookkeeping; last only moves once a burst has fully completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q    <= '0;
            last_q <= IW'(N_REQ - 1);
            rem_q  <= '0;
        end else if (state == ST_IDLE) begin
            if (admit) begin
                w_q   <= pick_idx;
                rem_q <= sel_len;
            end
        end else if (!fifo_full) begin
            if (rem_q == '0) last_q <= w_q;
            else             rem_q  <= rem_q - LEN_W'(1);
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants  <= '0;
            stat_stalls  <= '0;
            stat_blocked <= '0;
        end else begin
            if (state == ST_IDLE && admit)
                stat_grants[pick_idx*STAT_W +: STAT_W] <=
                    sat_inc(stat_grants[pick_idx*STAT_W +: STAT_W]);
            if (state == ST_BURST && fifo_full)
                stat_stalls <= sat_inc(stat_stalls);
            if (state == ST_IDLE && pick_any && !admit)
                stat_blocked <= sat_inc(stat_blocked);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: cycle table for grant/handshake outputs, queue of
// expected FIFO writes checked on every fifo_wr_en, plus hand-written
// sequences for mid-burst request drop, mid-burst reset and statistics.
module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N-1:0]         req;
    logic [N*LEN_W-1:0]   req_len;
    logic [N*DW-1:0]      req_data;
    logic [N-1:0]         gnt;
    logic [N-1:0]         data_ack;
    logic                 fifo_wr_en;
    logic [DW-1:0]        fifo_din;
    logic                 fifo_full;
    logic [7:0]           fifo_count;
    logic                 busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0]      stat_grants;
    logic [15:0]          stat_stalls;
    logic [15:0]          stat_blocked;
`endif

    fifo_wr_arb #(
        .N_REQ (N),
        .DW    (DW),
        .DEPTH (64),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .gnt        (gnt),
        .data_ack   (data_ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_grants  (stat_grants),
        .stat_stalls  (stat_stalls),
        .stat_blocked (stat_blocked)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Producers: lane i presents {i, word_count}; the count advances after each ack.
    logic [5:0]   prod_cnt [N] = '{default: '0};
    logic [N-1:0] ack_seen = '0;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {2'(i), prod_cnt[i]};
    end

    always @(negedge clk) ack_seen <= data_ack;
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (ack_seen[i]) prod_cnt[i] <= prod_cnt[i] + 6'd1;
    end

    // Scoreboard of expected FIFO writes.
    typedef struct {
        int         lane;
        logic [7:0] dat;
    } exp_t;
    exp_t       sb[$];
    logic [5:0] exp_cnt [N] = '{default: '0};

    task automatic push_words(input int lane, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.lane = lane;
            e.dat  = {2'(lane), exp_cnt[lane]};
            sb.push_back(e);
            exp_cnt[lane] = exp_cnt[lane] + 6'd1;
        end
    endtask

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got ack=%b din=%h, want no write", data_ack, fifo_din);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_ack !== (4'b0001 << e.lane) || fifo_din !== e.dat) begin
                    miscompares++;
                    $display("FAIL write_data: got ack=%b din=%h, want ack=%b din=%h",
                             data_ack, fifo_din, 4'b0001 << e.lane, e.dat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle table: inputs for one cycle and the outputs expected in it.
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic [7:0]  cnt;
        logic        full;
        logic [3:0]  gnt;
        logic        busy;
        logic        wr;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input int r, input int rq, input int ln, input int cn,
                     input int fl, input int g, input int bz, input int w);
        vec_t e;
        e.rst  = 1'(r);
        e.req  = 4'(rq);
        e.len  = 16'(ln);
        e.cnt  = 8'(cn);
        e.full = 1'(fl);
        e.gnt  = 4'(g);
        e.busy = 1'(bz);
        e.wr   = 1'(w);
        tbl.push_back(e);
    endtask

    logic [31:0] got, want;
    logic [7:0]  din_chk;
    int          n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single 4-word burst from requester 0 straight after reset.
        v(0, 4'b0001, 16'h0003, 0, 0, 0, 0, 0);
        repeat (3) v(0, 4'b0001, 16'h0003, 0, 0, 4'b0001, 1, 1);
        v(0, 0, 16'h0003, 0, 0, 4'b0001, 1, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0);
        // All four requesting single-word bursts: order 0,1,2,3,0 with IDLE gaps.
        for (int b = 0; b < 5; b++) begin
            v(0, 4'hF, 0, 0, 0, 0, 0, 0);
            v(0, (b == 4) ? 0 : 4'hF, 0, 0, 0, 4'b0001 << (b % 4), 1, 1);
        end
        v(0, 0, 0, 0, 0, 0, 0, 0);
        // Admission: 8-word burst waits until fifo_count reaches 56.
        v(0, 4'b0100, 16'h0700, 60, 0, 0, 0, 0);
        v(0, 4'b0100, 16'h0700, 60, 0, 0, 0, 0);
        v(0, 4'b0100, 16'h0700, 57, 0, 0, 0, 0);
        v(0, 4'b0100, 16'h0700, 56, 0, 0, 0, 0);
        repeat (8) v(0, 0, 16'h0700, 56, 0, 4'b0100, 1, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0);
        // fifo_full stalls for 3 cycles inside a 4-word burst.
        v(0, 4'b1000, 16'h3000, 0, 0, 0, 0, 0);
        v(0, 0, 16'h3000, 0, 0, 4'b1000, 1, 1);
        repeat (3) v(0, 0, 16'h3000, 0, 1, 4'b1000, 1, 0);
        repeat (3) v(0, 0, 16'h3000, 0, 0, 4'b1000, 1, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0);

        push_words(0, 4);
        push_words(0, 1); push_words(1, 1); push_words(2, 1); push_words(3, 1); push_words(0, 1);
        push_words(2, 8);
        push_words(3, 4);

        rst = 1'b1; req = '0; req_len = '0; fifo_full = 1'b0; fifo_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst        = tbl[i].rst;
            req        = tbl[i].req;
            req_len    = tbl[i].len;
            fifo_count = tbl[i].cnt;
            fifo_full  = tbl[i].full;
            #1;
            din_chk = tbl[i].busy ? 8'h00 : fifo_din;
            got  = {12'h0, gnt, data_ack, 2'b0, busy, fifo_wr_en, din_chk};
            want = {12'h0, tbl[i].gnt, (tbl[i].wr ? tbl[i].gnt : 4'h0), 2'b0,
                    tbl[i].busy, tbl[i].wr, 8'h00};
            check($sformatf("row%0d", i), got, want);
            tick;
        end
        rst = 1'b0; req = '0; req_len = '0; fifo_count = '0; fifo_full = 1'b0;

        // Requester 1 drops req after its first ack; all 6 words still land.
        req_len = 16'h0050;
        req     = 4'b0010;
        #1;
        check("drop_idle", 32'(busy), 32'd0);
        push_words(1, 6);
        tick;
        check("drop_gnt", 32'({gnt, fifo_wr_en}), 32'({4'b0010, 1'b1}));
        req = '0;
        n = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            if (fifo_wr_en) n++;
            tick;
        end
        check("drop_words", 32'(n), 32'd6);
        check("drop_done", 32'(busy), 32'd0);

        // Reset during word 5 of a 16-word burst from requester 2.
        req_len = 16'h0F00;
        req     = 4'b0100;
        push_words(2, 5);
        tick;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("rst_word%0d", k), 32'({gnt, fifo_wr_en}), 32'({4'b0100, 1'b1}));
            if (k == 5) begin
                rst = 1'b1;
                req = '0;
            end
            tick;
        end
        rst = 1'b0;
        #1;
        check("rst_outputs", 32'({gnt, data_ack, fifo_wr_en, busy, fifo_din}), 32'd0);
        req     = 4'b1111;
        req_len = '0;
        push_words(0, 1);
        tick;
        check("rst_regrant", 32'(gnt), 32'b0001);
        req = '0;
        tick;
        check("rst_idle", 32'(busy), 32'd0);

`ifdef FIFO_ARB_STATS_EN
        // Three single-word bursts from requester 1, first one stalled twice.
        rst = 1'b1;
        tick;
        rst     = 1'b0;
        req     = 4'b0010;
        req_len = '0;
        push_words(1, 3);
        tick;
        fifo_full = 1'b1;
        tick;
        tick;
        fifo_full = 1'b0;
        repeat (4) tick;
        req = '0;
        tick;
        check("stat_grants1", 32'(stat_grants[31:16]), 32'd3);
        check("stat_grants0", 32'(stat_grants[15:0]), 32'd0);
        check("stat_stalls", 32'(stat_stalls), 32'd2);
        check("stat_blocked", 32'(stat_blocked), 32'd0);
`endif

        tick;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
